// File: rtl/i2c_slave_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_ctrl_if
// Brief    : Bus-side and upstream-side signal bundle of the I2C slave
//            controller. The slave modport is the controller's view; the
//            master modport is the view of whatever drives it (pads/upstream).
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_slave_ctrl_if;
  logic       scl_i;     // raw SCL pad input, asynchronous
  logic       sda_i;     // raw SDA pad input, asynchronous
  logic       sda_oe;    // 1 = pull SDA low
  logic [7:0] rx_data;   // last complete byte written by the master
  logic       rx_valid;  // one-cycle pulse on rx_data update
  logic [7:0] tx_data;   // next byte to return on a read
  logic       tx_req;    // one-cycle pulse: tx_data consumed
  logic       busy;      // controller not idle

  modport slave (
    input  scl_i, sda_i, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, busy
  );

  modport master (
    output scl_i, sda_i, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, busy
  );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_ctrl
// Brief    : Byte-level I2C slave protocol controller. Synchronizes and
//            glitch-filters SCL/SDA, decodes START/STOP, matches a 7-bit
//            address, shifts write bytes in and read bytes out, and drives
//            SDA open-drain for ACK and read data.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_ctrl #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h42,
  parameter int unsigned FILTER_LEN = 3
) (
  input logic             iclk,
  input logic             reset,
  i2c_slave_ctrl_if.slave bus
);

  // The filter flips on the FILTER_LEN-th consecutive differing sample.
  localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
  localparam logic [2:0] ST_WRITE     = 3'd3;
  localparam logic [2:0] ST_WRITE_ACK = 3'd4;
  localparam logic [2:0] ST_READ      = 3'd5;
  localparam logic [2:0] ST_READ_ACK  = 3'd6;
  localparam logic [2:0] ST_WAIT_STOP = 3'd7;

  // Index 0 = SCL, index 1 = SDA.
  logic [1:0] raw_line;
  logic [1:0] filt_line;

  assign raw_line = {bus.sda_i, bus.scl_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic       sync1;
      logic       sync2;
      logic       filt;
      logic [3:0] run_cnt;

      // Two-flop synchronizer followed by a run-length glitch filter; idle bus is high.
      always_ff @(posedge iclk) begin
        if (reset) begin
          sync1   <= 1'b1;
          sync2   <= 1'b1;
          filt    <= 1'b1;
          run_cnt <= 4'd0;
        end else begin
          sync1 <= raw_line[gi];
          sync2 <= sync1;
          if (sync2 == filt) begin
            run_cnt <= 4'd0;
          end else if (run_cnt == FILT_MAX) begin
            filt    <= sync2;
            run_cnt <= 4'd0;
          end else begin
            run_cnt <= run_cnt + 4'd1;
          end
        end
      end

      assign filt_line[gi] = filt;
    end
  endgenerate

  logic scl_f;
  logic sda_f;
  logic scl_q;
  logic sda_q;
  logic scl_rise;
  logic scl_fall;
  logic start_ev;
  logic stop_ev;

  assign scl_f = filt_line[0];
  assign sda_f = filt_line[1];

  // Previous filtered sample, used for edge and START/STOP decode.
  always_ff @(posedge iclk) begin
    if (reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // START/STOP need SCL high in both samples, so a simultaneous SDA/SCL
  // change is only ever seen as an SCL edge.
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_ev = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_ev  = scl_f & scl_q & ~sda_q & sda_f;

  logic [2:0] state,     state_n;
  logic [3:0] bit_cnt,   bit_cnt_n;
  logic [7:0] shreg,     shreg_n;
  logic       rw,        rw_n;
  logic       sda_oe_r,  sda_oe_n;
  logic [7:0] rx_data_r, rx_data_n;
  logic       rx_vld_r,  rx_vld_n;
  logic       tx_req_r,  tx_req_n;

  // State and datapath registers.
  always_ff @(posedge iclk) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      rw        <= 1'b0;
      sda_oe_r  <= 1'b0;
      rx_data_r <= 8'h00;
      rx_vld_r  <= 1'b0;
      tx_req_r  <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      rw        <= rw_n;
      sda_oe_r  <= sda_oe_n;
      rx_data_r <= rx_data_n;
      rx_vld_r  <= rx_vld_n;
      tx_req_r  <= tx_req_n;
    end
  end

  // Next-state logic: bus conditions first, then per-state SCL edge handling.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    rw_n      = rw;
    sda_oe_n  = sda_oe_r;
    rx_data_n = rx_data_r;
    rx_vld_n  = 1'b0;
    tx_req_n  = 1'b0;

    if (start_ev) begin
      state_n   = ST_ADDR;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
    end else if (stop_ev) begin
      state_n   = ST_IDLE;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shreg_n   = {shreg[6:0], sda_f};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = 4'd0;
            if (shreg[7:1] == SLAVE_ADDR) begin
              rw_n     = shreg[0];
              sda_oe_n = 1'b1;
              state_n  = ST_ADDR_ACK;
            end else begin
              state_n  = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = 4'd0;
            if (!rw) begin
              sda_oe_n = 1'b0;
              state_n  = ST_WRITE;
            end else begin
              shreg_n  = bus.tx_data;
              tx_req_n = 1'b1;
              sda_oe_n = ~bus.tx_data[7];
              state_n  = ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shreg_n   = {shreg[6:0], sda_f};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              rx_data_n = {shreg[6:0], sda_f};
              rx_vld_n  = 1'b1;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b1;
            state_n   = ST_WRITE_ACK;
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = ST_WRITE;
          end
        end
        ST_READ: begin
          // Bit 7 is already on the bus at entry; each later fall presents the next bit.
          if (scl_rise && bit_cnt < 4'd8) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            if (bit_cnt == 4'd8) begin
              bit_cnt_n = 4'd0;
              sda_oe_n  = 1'b0;
              state_n   = ST_READ_ACK;
            end else begin
              shreg_n  = {shreg[6:0], 1'b0};
              sda_oe_n = ~shreg[6];
            end
          end
        end
        ST_READ_ACK: begin
          // A NACK leaves at the rise, so any fall seen here follows an ACK.
          if (scl_rise && sda_f) begin
            state_n = ST_WAIT_STOP;
          end else if (scl_fall) begin
            shreg_n   = bus.tx_data;
            tx_req_n  = 1'b1;
            sda_oe_n  = ~bus.tx_data[7];
            bit_cnt_n = 4'd0;
            state_n   = ST_READ;
          end
        end
        ST_WAIT_STOP: begin
          sda_oe_n = 1'b0;
        end
        default: begin
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  // Output drive from registered state.
  always_comb begin
    bus.sda_oe   = sda_oe_r;
    bus.rx_data  = rx_data_r;
    bus.rx_valid = rx_vld_r;
    bus.tx_req   = tx_req_r;
    bus.busy     = (state != ST_IDLE);
  end

endmodule
`default_nettype wire
